// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions for the register-interface read and write sides.
package axil_pkg;

  localparam int unsigned AXIL_RESP_W = 2;
  localparam int unsigned AXIL_PROT_W = 3;

  localparam logic [AXIL_RESP_W-1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [AXIL_RESP_W-1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_REQ  = 2'd1,
    RD_RESP = 2'd2
  } axil_rd_state_e;

endpackage

// File: rtl/axil_reg_if_rd_if.sv
// AXI-Lite read channel plus register-side read port, bundled for the read bridge.
interface axil_reg_if_rd_if
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]  s_axil_araddr;
  logic [AXIL_PROT_W-1:0] s_axil_arprot;
  logic                   s_axil_arvalid;
  logic                   s_axil_arready;
  logic [DATA_WIDTH-1:0]  s_axil_rdata;
  logic [AXIL_RESP_W-1:0] s_axil_rresp;
  logic                   s_axil_rvalid;
  logic                   s_axil_rready;

  logic [ADDR_WIDTH-1:0]  reg_rd_addr;
  logic                   reg_rd_en;
  logic [DATA_WIDTH-1:0]  reg_rd_data;
  logic                   reg_rd_wait;
  logic                   reg_rd_ack;

  modport slave (
    input  s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
    output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
    output reg_rd_addr, reg_rd_en,
    input  reg_rd_data, reg_rd_wait, reg_rd_ack
  );

  modport master (
    output s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
    input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
    input  reg_rd_addr, reg_rd_en,
    output reg_rd_data, reg_rd_wait, reg_rd_ack
  );

endinterface

// File: rtl/axil_reg_if_rd.sv
// AXI-Lite read slave bridging to a simple register read port, with a wait-aware
// response timeout that returns SLVERR when the register side never acknowledges.
module axil_reg_if_rd
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  axil_reg_if_rd_if.slave  bus
);

  localparam int unsigned        CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(TIMEOUT - 1);

  // Unsupported configurations are flagged by this named scope in the elaborated hierarchy.
  if ((STRB_WIDTH * 8 != DATA_WIDTH) || (TIMEOUT < 2)) begin : g_illegal_config
  end

  axil_rd_state_e              r_state;
  axil_rd_state_e              w_state_next;
  logic                        w_load;
  logic                        w_dec;
  logic                        w_done;
  logic                        w_timeout;

  logic                        r_arready;
  logic                        r_rd_en;
  logic                        r_rvalid;
  logic [DATA_WIDTH-1:0]       r_rdata;
  logic [AXIL_RESP_W-1:0]      r_rresp;
  logic [ADDR_WIDTH-1:0]       r_rd_addr;
  logic [CNT_W-1:0]            r_cnt;
  logic                        w_unused_arprot;

  assign w_unused_arprot = ^bus.s_axil_arprot;

  // Next-state: an ack always wins over an expiring counter.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (bus.s_axil_arvalid && r_arready) begin
          w_state_next = RD_REQ;
          w_load       = 1'b1;
        end
      end
      RD_REQ: begin
        if (bus.reg_rd_ack) begin
          w_state_next = RD_RESP;
          w_done       = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_next = RD_RESP;
          w_timeout    = 1'b1;
        end else if (!bus.reg_rd_wait) begin
          w_dec        = 1'b1;
        end
      end
      RD_RESP: begin
        if (bus.s_axil_rready) begin
          w_state_next = RD_IDLE;
        end
      end
      default: w_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RD_IDLE;
      r_arready <= 1'b1;
      r_rd_en   <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= AXIL_RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_arready <= (w_state_next == RD_IDLE);
      r_rd_en   <= (w_state_next == RD_REQ);
      r_rvalid  <= (w_state_next == RD_RESP);
      if (w_done) begin
        r_rdata <= bus.reg_rd_data;
        r_rresp <= AXIL_RESP_OKAY;
      end else if (w_timeout) begin
        r_rdata <= '0;
        r_rresp <= AXIL_RESP_SLVERR;
      end
    end
  end

  // Address and timeout counter are only meaningful after an AR handshake.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_rd_addr <= bus.s_axil_araddr;
      r_cnt     <= CNT_LOAD;
    end else if (w_dec) begin
      r_cnt     <= r_cnt - CNT_W'(1);
    end
  end

  assign bus.s_axil_arready = r_arready;
  assign bus.s_axil_rvalid  = r_rvalid;
  assign bus.s_axil_rdata   = r_rdata;
  assign bus.s_axil_rresp   = r_rresp;
  assign bus.reg_rd_addr    = r_rd_addr;
  assign bus.reg_rd_en      = r_rd_en;

endmodule

// File: tb/tb_axil_reg_if_rd.sv
// Directed bench for axil_reg_if_rd: completion, timeout, wait stall, backpressure,
// ack/timeout race, back-to-back reads and mid-transaction reset.
module tb_axil_reg_if_rd;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  axil_reg_if_rd_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  axil_reg_if_rd #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .STRB_WIDTH (4),
    .TIMEOUT    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_read(input logic [31:0] addr);
    bus.s_axil_araddr  = addr;
    bus.s_axil_arvalid = 1'b1;
    tick();
    bus.s_axil_arvalid = 1'b0;
  endtask

  task automatic finish_read();
    bus.s_axil_rready = 1'b1;
    tick();
    bus.s_axil_rready = 1'b0;
  endtask

  task automatic test_reset();
    rst                = 1'b1;
    bus.s_axil_araddr  = '0;
    bus.s_axil_arprot  = '0;
    bus.s_axil_arvalid = 1'b0;
    bus.s_axil_rready  = 1'b0;
    bus.reg_rd_data    = '0;
    bus.reg_rd_wait    = 1'b0;
    bus.reg_rd_ack     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_vec++; if (bus.s_axil_arready !== 1'b1) begin n_err++; $display("FAIL reset_arready got=%b exp=1", bus.s_axil_arready); end
    n_vec++; if (bus.s_axil_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got=%b exp=0", bus.s_axil_rvalid); end
    n_vec++; if (bus.reg_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got=%b exp=0", bus.reg_rd_en); end
    n_vec++; if (bus.s_axil_rresp !== 2'b00) begin n_err++; $display("FAIL reset_rresp got=%b exp=00", bus.s_axil_rresp); end
    n_vec++; if (bus.s_axil_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", bus.s_axil_rdata); end
  endtask

  task automatic test_single_read();
    start_read(32'h0000_0010);
    n_vec++; if (bus.reg_rd_en !== 1'b1) begin n_err++; $display("FAIL single_rd_en got=%b exp=1", bus.reg_rd_en); end
    n_vec++; if (bus.s_axil_arready !== 1'b0) begin n_err++; $display("FAIL single_arready got=%b exp=0", bus.s_axil_arready); end
    n_vec++; if (bus.reg_rd_addr !== 32'h0000_0010) begin n_err++; $display("FAIL single_rd_addr got=%h exp=00000010", bus.reg_rd_addr); end
    tick();
    tick();
    bus.reg_rd_ack  = 1'b1;
    bus.reg_rd_data = 32'hA5A5_0001;
    n_vec++; if (bus.s_axil_rvalid !== 1'b0) begin n_err++; $display("FAIL single_early_rvalid got=%b exp=0", bus.s_axil_rvalid); end
    tick();
    bus.reg_rd_ack  = 1'b0;
    bus.reg_rd_data = '0;
    n_vec++; if (bus.s_axil_rvalid !== 1'b1) begin n_err++; $display("FAIL single_rvalid got=%b exp=1", bus.s_axil_rvalid); end
    n_vec++; if (bus.s_axil_rdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_rdata got=%h exp=a5a50001", bus.s_axil_rdata); end
    n_vec++; if (bus.s_axil_rresp !== 2'b00) begin n_err++; $display("FAIL single_rresp got=%b exp=00", bus.s_axil_rresp); end
    n_vec++; if (bus.reg_rd_en !== 1'b0) begin n_err++; $display("FAIL single_rd_en_drop got=%b exp=0", bus.reg_rd_en); end
    finish_read();
    n_vec++; if (bus.s_axil_rvalid !== 1'b0) begin n_err++; $display("FAIL single_rvalid_clr got=%b exp=0", bus.s_axil_rvalid); end
    n_vec++; if (bus.s_axil_arready !== 1'b1) begin n_err++; $display("FAIL single_arready_back got=%b exp=1", bus.s_axil_arready); end
  endtask

  task automatic test_ack_idle();
    bus.reg_rd_ack  = 1'b1;
    bus.reg_rd_data = 32'hFFFF_FFFF;
    tick();
    tick();
    bus.reg_rd_ack  = 1'b0;
    n_vec++;
    if ({bus.s_axil_rvalid, bus.reg_rd_en, bus.s_axil_arready} !== 3'b001) begin
      n_err++;
      $display("FAIL idle_ack_ignored got rvalid/en/arready=%b exp=001",
               {bus.s_axil_rvalid, bus.reg_rd_en, bus.s_axil_arready});
    end
  endtask

  task automatic test_timeout();
    int cyc;
    start_read(32'h0000_0030);
    cyc = 1;
    while (!bus.s_axil_rvalid && cyc < 20) begin
      tick();
      cyc++;
    end
    n_vec++; if (cyc != 5) begin n_err++; $display("FAIL timeout_latency got=%0d exp=5", cyc); end
    n_vec++; if (bus.s_axil_rresp !== 2'b10) begin n_err++; $display("FAIL timeout_rresp got=%b exp=10", bus.s_axil_rresp); end
    n_vec++; if (bus.s_axil_rdata !== 32'h0) begin n_err++; $display("FAIL timeout_rdata got=%h exp=0", bus.s_axil_rdata); end
    n_vec++; if (bus.reg_rd_en !== 1'b0) begin n_err++; $display("FAIL timeout_rd_en got=%b exp=0", bus.reg_rd_en); end
    finish_read();
  endtask

  task automatic test_wait_stall();
    logic early;
    start_read(32'h0000_0034);
    bus.reg_rd_wait = 1'b1;
    early = 1'b0;
    repeat (10) begin
      tick();
      if (bus.s_axil_rvalid) early = 1'b1;
    end
    n_vec++; if (early !== 1'b0) begin n_err++; $display("FAIL wait_no_timeout got=%b exp=0", early); end
    bus.reg_rd_wait = 1'b0;
    bus.reg_rd_ack  = 1'b1;
    bus.reg_rd_data = 32'h1234_5678;
    tick();
    bus.reg_rd_ack  = 1'b0;
    n_vec++; if (bus.s_axil_rvalid !== 1'b1) begin n_err++; $display("FAIL wait_rvalid got=%b exp=1", bus.s_axil_rvalid); end
    n_vec++; if (bus.s_axil_rresp !== 2'b00) begin n_err++; $display("FAIL wait_rresp got=%b exp=00", bus.s_axil_rresp); end
    n_vec++; if (bus.s_axil_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL wait_rdata got=%h exp=12345678", bus.s_axil_rdata); end
    finish_read();
  endtask

  task automatic test_backpressure();
    start_read(32'h0000_0040);
    bus.reg_rd_ack  = 1'b1;
    bus.reg_rd_data = 32'hDEAD_BEEF;
    tick();
    n_vec++; if (bus.s_axil_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bp_first_rdata got=%h exp=deadbeef", bus.s_axil_rdata); end
    // Stray ack and a competing AR must both be ignored while the response waits.
    for (int i = 0; i < 6; i++) begin
      bus.s_axil_arvalid = 1'b1;
      bus.s_axil_araddr  = 32'h0000_0099;
      bus.reg_rd_data    = 32'hFFFF_0000;
      tick();
      n_vec++;
      if ({bus.s_axil_rvalid, bus.s_axil_arready, bus.reg_rd_en} !== 3'b100 ||
          bus.s_axil_rdata !== 32'hDEAD_BEEF || bus.s_axil_rresp !== 2'b00) begin
        n_err++;
        $display("FAIL bp_hold cyc=%0d got rvalid/arready/en=%b rdata=%h rresp=%b exp=100 deadbeef 00",
                 i, {bus.s_axil_rvalid, bus.s_axil_arready, bus.reg_rd_en},
                 bus.s_axil_rdata, bus.s_axil_rresp);
      end
    end
    bus.s_axil_arvalid = 1'b0;
    bus.reg_rd_ack     = 1'b0;
    finish_read();
    n_vec++;
    if ({bus.s_axil_rvalid, bus.s_axil_arready, bus.reg_rd_en} !== 3'b010) begin
      n_err++;
      $display("FAIL bp_release got rvalid/arready/en=%b exp=010",
               {bus.s_axil_rvalid, bus.s_axil_arready, bus.reg_rd_en});
    end
  endtask

  task automatic test_ack_at_zero();
    start_read(32'h0000_0050);
    tick();
    tick();
    tick();
    n_vec++; if (bus.s_axil_rvalid !== 1'b0) begin n_err++; $display("FAIL race_early_rvalid got=%b exp=0", bus.s_axil_rvalid); end
    bus.reg_rd_ack  = 1'b1;
    bus.reg_rd_data = 32'hCAFE_F00D;
    tick();
    bus.reg_rd_ack  = 1'b0;
    n_vec++; if (bus.s_axil_rvalid !== 1'b1) begin n_err++; $display("FAIL race_rvalid got=%b exp=1", bus.s_axil_rvalid); end
    n_vec++; if (bus.s_axil_rresp !== 2'b00) begin n_err++; $display("FAIL race_rresp got=%b exp=00", bus.s_axil_rresp); end
    n_vec++; if (bus.s_axil_rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL race_rdata got=%h exp=cafef00d", bus.s_axil_rdata); end
    finish_read();
  endtask

  task automatic test_back_to_back();
    start_read(32'h0000_0060);
    bus.reg_rd_ack  = 1'b1;
    bus.reg_rd_data = 32'h1111_1111;
    tick();
    bus.reg_rd_ack  = 1'b0;
    n_vec++; if (bus.s_axil_rdata !== 32'h1111_1111) begin n_err++; $display("FAIL b2b_rdata0 got=%h exp=11111111", bus.s_axil_rdata); end
    finish_read();
    n_vec++; if (bus.s_axil_arready !== 1'b1) begin n_err++; $display("FAIL b2b_arready got=%b exp=1", bus.s_axil_arready); end
    start_read(32'h0000_0064);
    n_vec++; if (bus.reg_rd_addr !== 32'h0000_0064) begin n_err++; $display("FAIL b2b_rd_addr got=%h exp=00000064", bus.reg_rd_addr); end
    bus.reg_rd_ack  = 1'b1;
    bus.reg_rd_data = 32'h2222_2222;
    tick();
    bus.reg_rd_ack  = 1'b0;
    n_vec++; if (bus.s_axil_rdata !== 32'h2222_2222) begin n_err++; $display("FAIL b2b_rdata1 got=%h exp=22222222", bus.s_axil_rdata); end
    finish_read();
  endtask

  task automatic test_reset_mid();
    start_read(32'h0000_0070);
    tick();
    n_vec++; if (bus.reg_rd_en !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_en got=%b exp=1", bus.reg_rd_en); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({bus.reg_rd_en, bus.s_axil_rvalid, bus.s_axil_arready} !== 3'b001) begin
      n_err++;
      $display("FAIL rstmid_abandon got en/rvalid/arready=%b exp=001",
               {bus.reg_rd_en, bus.s_axil_rvalid, bus.s_axil_arready});
    end
    tick();
    n_vec++; if (bus.s_axil_rvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_no_resp got=%b exp=0", bus.s_axil_rvalid); end
    start_read(32'h0000_0020);
    n_vec++; if (bus.reg_rd_addr !== 32'h0000_0020) begin n_err++; $display("FAIL rstmid_rd_addr got=%h exp=00000020", bus.reg_rd_addr); end
    bus.reg_rd_ack  = 1'b1;
    bus.reg_rd_data = 32'h0BAD_CAFE;
    tick();
    bus.reg_rd_ack  = 1'b0;
    n_vec++;
    if (bus.s_axil_rvalid !== 1'b1 || bus.s_axil_rresp !== 2'b00 || bus.s_axil_rdata !== 32'h0BAD_CAFE) begin
      n_err++;
      $display("FAIL rstmid_next_read got rvalid=%b rresp=%b rdata=%h exp=1 00 0badcafe",
               bus.s_axil_rvalid, bus.s_axil_rresp, bus.s_axil_rdata);
    end
    finish_read();
    n_vec++; if (bus.s_axil_arready !== 1'b1) begin n_err++; $display("FAIL rstmid_arready got=%b exp=1", bus.s_axil_arready); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_read();
    test_ack_idle();
    test_timeout();
    test_wait_stall();
    test_backpressure();
    test_ack_at_zero();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
